adc16dv160_delay_calib: RTL and testbench

Per-lane IDELAY calibration controller for the ADC16DV160 LVDS input. It sits beside the input receiver in the `adc_clk` domain while the ADC drives a known test pattern. It sweeps the input-delay taps 0..31 on all 8 DDR lanes in parallel and checks each lane's deserialized bits against the pattern. It then loads each lane's IDELAYE2 (VAR_LOAD mode) with the centre of that lane's widest passing tap window and reports per-lane pass/fail.

---
 rtl/adc16dv160_delay_calib_if.sv | 32 +++
 rtl/adc16dv160_delay_calib.sv | 178 +++++++++++++++++
 tb/tb_adc16dv160_delay_calib.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/adc16dv160_delay_calib_if.sv
// adc16dv160_delay_calib_if
// Groups the calibration controller's control and data signals.
//   slave  : the calibration controller (receives start/adc_data, drives the rest)
//   master : the environment (ADC receiver / sequencer side)
// Signals:
//   start             - begin a calibration (sampled in IDLE/DONE)
//   adc_data[15:0]    - IDDR outputs, lane i on bits [2i+1:2i]
//   idelay_ld[7:0]    - per-lane IDELAYE2 LD strobe
//   idelay_cntvaluein - per-lane tap value, lane i at [5i+4:5i]
//   lane_tap          - final tap per lane, same packing
//   lane_ok[7:0]      - lane found a wide enough eye
//   busy / done       - calibration in progress / result valid
interface adc16dv160_delay_calib_if;
  logic        start;
  logic [15:0] adc_data;
  logic [7:0]  idelay_ld;
  logic [39:0] idelay_cntvaluein;
  logic [39:0] lane_tap;
  logic [7:0]  lane_ok;
  logic        busy;
  logic        done;

  modport master (
    output start, adc_data,
    input  idelay_ld, idelay_cntvaluein, lane_tap, lane_ok, busy, done
  );

  modport slave (
    input  start, adc_data,
    output idelay_ld, idelay_cntvaluein, lane_tap, lane_ok, busy, done
  );
endinterface

// File: rtl/adc16dv160_delay_calib.sv
// adc16dv160_delay_calib
// Sweeps the IDELAYE2 taps 0..31 on all 8 DDR lanes in parallel while the ADC
// sends a fixed test pattern, finds each lane's widest passing tap window and
// loads the centre of that window (or DEFAULT_TAP for a lane without a usable
// eye) into the IDELAY.
// Ports:
//   adc_clk - ADC clock, all logic on its rising edge
//   adc_rst - synchronous active-high reset
//   bus     - slave side of adc16dv160_delay_calib_if
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start
// LOAD   | LD strobe with the sweep tap on every lane
// SETTLE | let the delay line settle, data ignored
// CHECK  | accumulate per-lane sticky compare errors
// EVAL   | fold this tap into the run trackers, next tap or finish
// APPLY  | LD strobe with the final per-lane taps, latch results
// DONE   | results valid, waiting for start
module adc16dv160_delay_calib #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned WINDOW        = 256,
  parameter logic [15:0] PATTERN       = 16'hAAAA,
  parameter int unsigned MIN_EYE       = 4,
  parameter int unsigned DEFAULT_TAP   = 0
) (
  input logic                      adc_clk,
  input logic                      adc_rst,
  adc16dv160_delay_calib_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_EVAL, S_APPLY, S_DONE
  } state_t;

  state_t      state;
  logic [4:0]  tap;
  logic [31:0] cnt;
  logic [7:0]  err;
  logic [4:0]  run_start  [8];
  logic [5:0]  run_len    [8];
  logic [4:0]  best_start [8];
  logic [5:0]  best_len   [8];

  logic [4:0]  nxt_run_start  [8];
  logic [5:0]  nxt_run_len    [8];
  logic [4:0]  nxt_best_start [8];
  logic [5:0]  nxt_best_len   [8];
  logic [4:0]  close_start    [8];
  logic [5:0]  close_len      [8];
  logic [7:0]  close_en;
  logic [39:0] final_taps;
  logic [4:0]  tap_inc;

  assign tap_inc = tap + 5'd1;

  // Run tracking for the EVAL cycle. On the last tap an open run is closed
  // too, so the best window also covers runs ending at tap 31.
  always_comb begin
    final_taps = '0;
    close_en   = '0;
    for (int i = 0; i < 8; i++) begin
      nxt_run_start[i]  = run_start[i];
      nxt_run_len[i]    = run_len[i];
      nxt_best_start[i] = best_start[i];
      nxt_best_len[i]   = best_len[i];
      close_start[i]    = run_start[i];
      close_len[i]      = run_len[i];
      if (!err[i]) begin
        nxt_run_len[i] = run_len[i] + 6'd1;
        if (run_len[i] == 6'd0) nxt_run_start[i] = tap;
        close_start[i] = nxt_run_start[i];
        close_len[i]   = nxt_run_len[i];
        close_en[i]    = (tap == 5'd31);
      end else begin
        nxt_run_len[i] = 6'd0;
        close_en[i]    = 1'b1;
      end
      // Strictly greater: the lowest-tap window wins a tie.
      if (close_en[i] && (close_len[i] > best_len[i])) begin
        nxt_best_start[i] = close_start[i];
        nxt_best_len[i]   = close_len[i];
      end
      if (nxt_best_len[i] >= 6'(MIN_EYE))
        final_taps[5*i +: 5] = nxt_best_start[i] + 5'((nxt_best_len[i] - 6'd1) >> 1);
      else
        final_taps[5*i +: 5] = 5'(DEFAULT_TAP);
    end
  end

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      state                 <= S_IDLE;
      tap                   <= '0;
      cnt                   <= '0;
      err                   <= '0;
      bus.busy              <= 1'b0;
      bus.done              <= 1'b0;
      bus.idelay_ld         <= '0;
      bus.idelay_cntvaluein <= '0;
      bus.lane_tap          <= '0;
      bus.lane_ok           <= '0;
      for (int i = 0; i < 8; i++) begin
        run_start[i]  <= '0;
        run_len[i]    <= '0;
        best_start[i] <= '0;
        best_len[i]   <= '0;
      end
    end else begin
      bus.idelay_ld <= '0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state                 <= S_LOAD;
            tap                   <= '0;
            err                   <= '0;
            bus.busy              <= 1'b1;
            bus.done              <= 1'b0;
            bus.idelay_ld         <= '1;
            bus.idelay_cntvaluein <= '0;
            for (int i = 0; i < 8; i++) begin
              run_start[i]  <= '0;
              run_len[i]    <= '0;
              best_start[i] <= '0;
              best_len[i]   <= '0;
            end
          end
        end
        S_LOAD: begin
          state <= S_SETTLE;
          cnt   <= 32'(SETTLE_CYCLES - 1);
        end
        S_SETTLE: begin
          if (cnt == 32'd0) begin
            state <= S_CHECK;
            cnt   <= 32'(WINDOW - 1);
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        S_CHECK: begin
          for (int i = 0; i < 8; i++)
            if (bus.adc_data[2*i +: 2] != PATTERN[2*i +: 2]) err[i] <= 1'b1;
          if (cnt == 32'd0) state <= S_EVAL;
          else              cnt   <= cnt - 32'd1;
        end
        S_EVAL: begin
          err <= '0;
          for (int i = 0; i < 8; i++) begin
            run_start[i]  <= nxt_run_start[i];
            run_len[i]    <= nxt_run_len[i];
            best_start[i] <= nxt_best_start[i];
            best_len[i]   <= nxt_best_len[i];
          end
          bus.idelay_ld <= '1;
          if (tap == 5'd31) begin
            state                 <= S_APPLY;
            bus.idelay_cntvaluein <= final_taps;
          end else begin
            state                 <= S_LOAD;
            tap                   <= tap_inc;
            bus.idelay_cntvaluein <= {8{tap_inc}};
          end
        end
        S_APPLY: begin
          state        <= S_DONE;
          bus.busy     <= 1'b0;
          bus.done     <= 1'b1;
          bus.lane_tap <= bus.idelay_cntvaluein;
          for (int i = 0; i < 8; i++)
            bus.lane_ok[i] <= (best_len[i] >= 6'(MIN_EYE));
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc16dv160_delay_calib.sv
// Testbench for adc16dv160_delay_calib: models the ADC + IDELAY lanes, drives
// random and directed eye masks, and compares against a window-search model.
module tb_adc16dv160_delay_calib;
  localparam int S = 16;
  localparam int W = 256;
  localparam int T = S + W + 2;
  localparam int MIN_EYE = 4;
  localparam int DEF_TAP = 0;

  logic adc_clk = 1'b0;
  logic adc_rst = 1'b1;
  always #5 adc_clk = ~adc_clk;

  adc16dv160_delay_calib_if bus ();

  adc16dv160_delay_calib dut (
    .adc_clk (adc_clk),
    .adc_rst (adc_rst),
    .bus     (bus)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          t0 = 0;
  int          n_ld = 0;
  int          since_ld = 0;
  bit          in_run = 0;
  logic [15:0] pat_v = 16'hAAAA;
  logic [4:0]  dly [8];
  logic [31:0] mask [8];
  int          glitch_tap [8];
  int          glitch_cyc [8];
  logic [39:0] exp_tap;
  logic [7:0]  exp_ok;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc - t0);
    end
  endtask

  // Expected result: longest run of passing taps, lowest start on a tie.
  // A glitch only counts when it lands inside the compare window.
  function automatic void model();
    exp_tap = '0;
    exp_ok  = '0;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] eff;
      int len, s, blen, bs;
      eff = mask[i];
      if (glitch_tap[i] >= 0 && glitch_cyc[i] >= S + 1 && glitch_cyc[i] <= S + W)
        eff[glitch_tap[i]] = 1'b0;
      len = 0; s = 0; blen = 0; bs = 0;
      for (int t = 0; t < 32; t++) begin
        if (eff[t]) begin
          if (len == 0) s = t;
          len++;
          if (len > blen) begin blen = len; bs = s; end
        end else len = 0;
      end
      exp_ok[i] = (blen >= MIN_EYE);
      exp_tap[5*i +: 5] = exp_ok[i] ? 5'(bs + (blen - 1) / 2) : 5'(DEF_TAP);
    end
  endfunction

  function automatic logic [31:0] rand_mask();
    logic [31:0] m;
    int nw;
    m = '0;
    if ($urandom_range(0, 7) == 0) return '1;
    nw = $urandom_range(0, 3);
    for (int w = 0; w < nw; w++) begin
      int s, l;
      s = $urandom_range(0, 31);
      l = $urandom_range(1, 12);
      for (int t = s; t < s + l && t < 32; t++) m[t] = 1'b1;
    end
    return m;
  endfunction

  function automatic void clear_glitches();
    for (int i = 0; i < 8; i++) begin glitch_tap[i] = -1; glitch_cyc[i] = -1; end
  endfunction

  // One clock: observe LD strobes (checked and latched into the lane delay
  // model), then drive adc_data for the current lane delays.
  task automatic tick();
    logic [15:0] d;
    logic [4:0]  k5;
    @(negedge adc_clk);
    cyc++;
    if (bus.idelay_ld != 8'h00) begin
      if (in_run) begin
        chk("ld_all_lanes", bus.idelay_ld, 8'hFF);
        k5 = n_ld[4:0];
        if (n_ld < 32)       chk("ld_sweep_tap", bus.idelay_cntvaluein, {8{k5}});
        else if (n_ld == 32) chk("ld_final_taps", bus.idelay_cntvaluein, exp_tap);
        chk("ld_cycle", cyc - t0, 1 + n_ld * T);
      end
      n_ld++;
      for (int i = 0; i < 8; i++) dly[i] = bus.idelay_cntvaluein[5*i +: 5];
      since_ld = 0;
    end else begin
      since_ld++;
    end
    for (int i = 0; i < 8; i++) begin
      logic [1:0] b;
      b = pat_v[2*i +: 2];
      if (!mask[i][dly[i]]) b = b ^ 2'($urandom_range(1, 3));
      if (glitch_tap[i] == int'(dly[i]) && glitch_cyc[i] == since_ld) b = b ^ 2'b01;
      d[2*i +: 2] = b;
    end
    bus.adc_data = d;
  endtask

  task automatic run_cal(input bit pulse_start, input int rst_at);
    bit prev_busy;
    model();
    n_ld = 0;
    in_run = 1;
    bus.start = 1'b1;
    t0 = cyc;
    tick();
    chk("busy_after_start", bus.busy, 1'b1);
    chk("done_cleared", bus.done, 1'b0);
    bus.start = 1'b0;
    prev_busy = bus.busy;
    for (int k = 0; k < 9000; k++) begin
      if (rst_at > 0 && cyc - t0 == rst_at) begin
        adc_rst = 1'b1;
        tick();
        adc_rst = 1'b0;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_ld", bus.idelay_ld, 8'h00);
        chk("rst_cntvalue", bus.idelay_cntvaluein, 40'h0);
        chk("rst_lane_tap", bus.lane_tap, 40'h0);
        chk("rst_lane_ok", bus.lane_ok, 8'h00);
        repeat (T) tick();
        chk("rst_stays_idle", {bus.busy, bus.done}, 2'b00);
        chk("rst_no_ld", n_ld, 10);
        in_run = 0;
        return;
      end
      if (pulse_start && (cyc - t0) < 32 * T - 10) bus.start = 1'($urandom_range(0, 1));
      else bus.start = 1'b0;
      prev_busy = bus.busy;
      tick();
      if (bus.done) break;
    end
    bus.start = 1'b0;
    chk("done_flag", bus.done, 1'b1);
    chk("done_cycle", cyc - t0, 32 * T + 2);
    chk("busy_before_done", prev_busy, 1'b1);
    chk("busy_fall_with_done", bus.busy, 1'b0);
    chk("ld_count", n_ld, 33);
    chk("lane_tap", bus.lane_tap, exp_tap);
    chk("lane_ok", bus.lane_ok, exp_ok);
    repeat (3) tick();
    chk("done_hold", bus.done, 1'b1);
    chk("cntvalue_hold", bus.idelay_cntvaluein, exp_tap);
    chk("lane_tap_hold", bus.lane_tap, exp_tap);
    in_run = 0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.adc_data = 16'hAAAA;
    for (int i = 0; i < 8; i++) begin dly[i] = '0; mask[i] = '1; end
    clear_glitches();

    adc_rst = 1'b1;
    repeat (3) tick();
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_ld", bus.idelay_ld, 8'h00);
    chk("reset_cntvalue", bus.idelay_cntvaluein, 40'h0);
    chk("reset_lane_tap", bus.lane_tap, 40'h0);
    chk("reset_lane_ok", bus.lane_ok, 8'h00);
    adc_rst = 1'b0;
    repeat (2) tick();

    // All lanes clean, start pulsed randomly while busy.
    run_cal(1'b1, 0);
    chk("all_good_taps", bus.lane_tap, {8{5'd15}});
    chk("all_good_ok", bus.lane_ok, 8'hFF);

    // Directed eye shapes and glitch placement at compare-window edges.
    for (int i = 0; i < 8; i++) mask[i] = '1;
    mask[3] = 32'h001F_FC00;
    mask[5] = 32'h01F0_007C;
    mask[6] = 32'h0000_0380;
    glitch_tap[0] = 16; glitch_cyc[0] = S + W;
    glitch_tap[1] = 20; glitch_cyc[1] = S;
    glitch_tap[2] = 5;  glitch_cyc[2] = S + W + 1;
    glitch_tap[4] = 0;  glitch_cyc[4] = S + 1;
    run_cal(1'b0, 0);
    chk("lane0_glitch_tap", bus.lane_tap[4:0], 5'd7);
    chk("lane1_settle_glitch_tap", bus.lane_tap[9:5], 5'd15);
    chk("lane3_tap", bus.lane_tap[19:15], 5'd15);
    chk("lane4_first_check_glitch_tap", bus.lane_tap[24:20], 5'd16);
    chk("lane5_tie_tap", bus.lane_tap[29:25], 5'd4);
    chk("lane6_short_tap", bus.lane_tap[34:30], 5'(DEF_TAP));
    chk("directed_ok", bus.lane_ok, 8'hBF);
    clear_glitches();

    // Random masks: reset during CHECK of tap 9, then a full sweep.
    for (int i = 0; i < 8; i++) mask[i] = rand_mask();
    run_cal(1'b0, 1 + 9 * T + 1 + S + 50);
    run_cal(1'b0, 0);

    for (int i = 0; i < 8; i++) mask[i] = rand_mask();
    glitch_tap[$urandom_range(0, 7)] = $urandom_range(0, 31);
    for (int i = 0; i < 8; i++) glitch_cyc[i] = $urandom_range(1, S + W + 1);
    run_cal(1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
